// File: rtl/elastic_fifo_struct_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | elastic_pkg : width helpers and the wrap increment for the FIFO  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package elastic_pkg;

   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit compare-and-clear so DEPTH need not be a power of two.
   function automatic int ptr_next(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_fifo_struct_storage.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | fifo_storage_mem : DEPTH-entry array, sync write, async read     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_storage_mem
   import elastic_pkg::*;
#(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 4,
   localparam int AW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  T              wdata,
   input  logic [AW-1:0] raddr,
   output T              rdata
);

   T r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/elastic_fifo_struct.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | elastic_fifo_struct : DEPTH-entry ready/valid elastic buffer     |
// | with optional zero-latency bypass, flush and occupancy count     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module elastic_fifo_struct
   import elastic_pkg::*;
#(
   parameter type T      = logic [31:0],
   parameter int  DEPTH  = 4,
   parameter bit  BYPASS = 1'b1,
   localparam int CW     = cnt_width(DEPTH),
   localparam int PW     = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          valid_in,
   output logic          ready_in,
   input  T              data_in,
   output logic          valid_out,
   input  logic          ready_out,
   output T              data_out,
   output logic [CW-1:0] count
);

   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic          w_we;
   logic          w_rd_adv;
   T              w_rdata;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   if (BYPASS) begin : g_bypass
      assign w_bypass = w_empty;
   end else begin : g_registered
      assign w_bypass = 1'b0;
   end

   // A reset cycle behaves like a flush: no handshake can complete.
   assign ready_in  = !w_full && !flush && !reset;
   assign valid_out = !flush && !reset && (w_bypass ? valid_in : !w_empty);
   assign data_out  = w_bypass ? data_in : w_rdata;
   assign count     = r_count;

   assign w_push   = valid_in && ready_in;
   assign w_pop    = valid_out && ready_out;
   assign w_rd_adv = w_pop && !w_empty;
   // A pop while bypassing always coincides with a push; that item skips storage.
   assign w_we     = w_push && !(w_bypass && w_pop);

   fifo_storage_mem #(.T(T), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_wr_ptr),
      .wdata (data_in),
      .raddr (r_rd_ptr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_we) begin
            r_wr_ptr <= PW'(ptr_next(int'(r_wr_ptr), DEPTH));
         end
         if (w_rd_adv) begin
            r_rd_ptr <= PW'(ptr_next(int'(r_rd_ptr), DEPTH));
         end
         if (w_we && !w_rd_adv) begin
            r_count <= r_count + CW'(1);
         end else if (!w_we && w_rd_adv) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

`ifndef SYNTHESIS
   logic r_stall;
   T     r_stall_data;

   always_ff @(posedge clk) begin
      r_stall      <= reset ? 1'b0 : (valid_out && !ready_out && !flush);
      r_stall_data <= data_out;
   end

   always @(posedge clk) begin
      if (!reset) begin
         assert (!(w_push && w_full));
         assert (!(w_pop && w_empty && !w_bypass));
         if (r_stall && !flush) begin
            assert (data_out == r_stall_data);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_fifo_struct.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_elastic_fifo_struct : scoreboard bench over four configs      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_elastic_fifo_struct;

   // Instance map: 0 = D4/registered, 1 = D4/bypass, 2 = D3/registered, 3 = D3/bypass
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [4];
   logic        fl   [4];
   logic        vin  [4];
   logic        rdy  [4];
   logic [31:0] din  [4];
   logic        vout [4];
   logic        rout [4];
   logic [31:0] dout [4];
   logic [2:0]  cnt  [4];
   logic [1:0]  cnt3_b0;
   logic [1:0]  cnt3_b1;
   logic [31:0] expq [4][$];
   int          total = 0;
   int          bad   = 0;

   assign cnt[2] = {1'b0, cnt3_b0};
   assign cnt[3] = {1'b0, cnt3_b1};

   elastic_fifo_struct #(.T(logic [31:0]), .DEPTH(4), .BYPASS(1'b0)) u_d4b0 (
      .clk(clk), .reset(rst[0]), .flush(fl[0]), .valid_in(vin[0]), .ready_in(rdy[0]),
      .data_in(din[0]), .valid_out(vout[0]), .ready_out(rout[0]), .data_out(dout[0]),
      .count(cnt[0]));
   elastic_fifo_struct #(.T(logic [31:0]), .DEPTH(4), .BYPASS(1'b1)) u_d4b1 (
      .clk(clk), .reset(rst[1]), .flush(fl[1]), .valid_in(vin[1]), .ready_in(rdy[1]),
      .data_in(din[1]), .valid_out(vout[1]), .ready_out(rout[1]), .data_out(dout[1]),
      .count(cnt[1]));
   elastic_fifo_struct #(.T(logic [31:0]), .DEPTH(3), .BYPASS(1'b0)) u_d3b0 (
      .clk(clk), .reset(rst[2]), .flush(fl[2]), .valid_in(vin[2]), .ready_in(rdy[2]),
      .data_in(din[2]), .valid_out(vout[2]), .ready_out(rout[2]), .data_out(dout[2]),
      .count(cnt3_b0));
   elastic_fifo_struct #(.T(logic [31:0]), .DEPTH(3), .BYPASS(1'b1)) u_d3b1 (
      .clk(clk), .reset(rst[3]), .flush(fl[3]), .valid_in(vin[3]), .ready_in(rdy[3]),
      .data_in(din[3]), .valid_out(vout[3]), .ready_out(rout[3]), .data_out(dout[3]),
      .count(cnt3_b1));

   task automatic check(input int k, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d got=%0h want=%0h", name, k, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int k, input logic [31:0] d);
      vin[k] = 1'b1;
      din[k] = d;
      expq[k].push_back(d);
   endtask

   task automatic drain(input int k);
      vin[k]  = 1'b0;
      rout[k] = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (expq[k].size() == 0 && cnt[k] == 3'd0) break;
         tick();
      end
      check(k, "drain_queue", expq[k].size(), 0);
      check(k, "drain_count", cnt[k], 0);
      tick();
      rout[k] = 1'b0;
   endtask

   // Monitor: every downstream transfer must match the head of the expected queue.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (vout[k] && rout[k]) begin
            if (expq[k].size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected inst=%0d got=%0h want=none", k, dout[k]);
            end else begin
               check(k, "out_data", dout[k], expq[k].pop_front());
            end
         end
      end
   end

   task automatic scen_stream(input int k);
      rout[k] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         issue(k, i);
         @(negedge clk);
         check(k, "s1_count", cnt[k], (k == 1 || i == 1) ? 0 : 1);
         check(k, "s1_valid_out", vout[k], (k == 1 || i > 1) ? 1 : 0);
         tick();
      end
      drain(k);
   endtask

   task automatic scen_backpressure(input int k);
      int dep;
      int acc;
      bit take;
      dep = (k < 2) ? 4 : 3;
      acc = 0;
      rout[k] = 1'b0;
      issue(k, 32'hA0);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == dep || c == dep + 1) begin
            check(k, "s2_ready_full", rdy[k], 0);
            check(k, "s2_count_full", cnt[k], dep);
         end
         take = vin[k] && rdy[k];
         tick();
         if (c == dep + 1) rout[k] = 1'b1;
         if (take) begin
            acc++;
            if (acc < 6) issue(k, 32'hA0 + acc);
            else vin[k] = 1'b0;
         end
         if (acc >= 6 && expq[k].size() == 0) break;
      end
      drain(k);
   endtask

   task automatic scen_steady(input int k);
      rout[k] = 1'b0;
      issue(k, 32'hB0); @(negedge clk); tick();
      issue(k, 32'hB1); @(negedge clk); tick();
      rout[k] = 1'b1;
      for (int i = 2; i < 12; i++) begin
         issue(k, 32'hB0 + i);
         @(negedge clk);
         check(k, "s3_count", cnt[k], 2);
         check(k, "s3_ready", rdy[k], 1);
         tick();
      end
      drain(k);
   endtask

   task automatic scen_full_pop(input int k);
      rout[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(k, 32'hC0 + i); @(negedge clk); tick();
      end
      issue(k, 32'hC4);
      rout[k] = 1'b1;
      @(negedge clk);
      check(k, "s4_ready_full", rdy[k], 0);
      check(k, "s4_count_full", cnt[k], 4);
      tick();
      @(negedge clk);
      check(k, "s4_ready_next", rdy[k], 1);
      check(k, "s4_count_next", cnt[k], 3);
      tick();
      drain(k);
   endtask

   task automatic scen_flush(input int k);
      rout[k] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(k, 32'hD0 + i); @(negedge clk); tick();
      end
      fl[k]  = 1'b1;
      vin[k] = 1'b1;
      din[k] = 32'hDF;
      expq[k].delete();
      @(negedge clk);
      check(k, "s5_valid_out", vout[k], 0);
      check(k, "s5_ready_in", rdy[k], 0);
      tick();
      fl[k] = 1'b0;
      issue(k, 32'hE0);
      rout[k] = 1'b1;
      @(negedge clk);
      check(k, "s5_count_after", cnt[k], 0);
      check(k, "s5_valid_after", vout[k], (k == 1) ? 1 : 0);
      tick();
      drain(k);
   endtask

   task automatic scen_reset(input int k);
      rout[k] = 1'b0;
      issue(k, 32'hF0); @(negedge clk); tick();
      issue(k, 32'hF1); @(negedge clk); tick();
      rst[k]  = 1'b1;
      vin[k]  = 1'b1;
      din[k]  = 32'hF2;
      rout[k] = 1'b1;
      expq[k].delete();
      @(negedge clk);
      tick();
      rst[k]  = 1'b0;
      vin[k]  = 1'b0;
      rout[k] = 1'b0;
      @(negedge clk);
      check(k, "s6_count", cnt[k], 0);
      check(k, "s6_valid_out", vout[k], 0);
      tick();
      rout[k] = 1'b1;
      issue(k, 32'h60); @(negedge clk); tick();
      issue(k, 32'h61); @(negedge clk); tick();
      drain(k);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         rst[k]  = 1'b1;
         fl[k]   = 1'b0;
         vin[k]  = 1'b0;
         rout[k] = 1'b0;
         din[k]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) rst[k] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check(k, "rst_count", cnt[k], 0);
         check(k, "rst_valid_out", vout[k], 0);
         check(k, "rst_ready_in", rdy[k], 1);
      end
      tick();
      for (int k = 0; k < 2; k++) scen_stream(k);
      for (int k = 0; k < 4; k++) scen_backpressure(k);
      for (int k = 0; k < 2; k++) scen_steady(k);
      for (int k = 0; k < 2; k++) scen_full_pop(k);
      for (int k = 0; k < 2; k++) scen_flush(k);
      for (int k = 0; k < 2; k++) scen_reset(k);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog inst=-1 got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
